spi_cs_sequencer: RTL and testbench

Upstream transaction controller for the byte-level SPI master. It accepts multi-byte transfers from a host, gives each one a single active-low chip-select window, and forwards bytes to the master one at a time using the master's TX_Ready handshake. It returns received bytes with a per-transaction byte index and enforces a minimum CS-high gap between transactions. The block does not instantiate the master; it connects to the master's TX/RX ports.

---
 rtl/spi_cs_sequencer.sv | 117 +++++++++++
 tb/tb_spi_cs_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cs_sequencer.sv
// Transaction sequencer in front of a byte-level SPI master. It holds one CS-low window per
// multi-byte transfer, paces bytes on the master's ready handshake and tags each RX byte with its index.
module spi_cs_sequencer #(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CS_INACTIVE_CLKS = 1,
  localparam int CNT_W = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [CNT_W-1:0] i_TX_Count,
  input  logic [7:0]       i_TX_Byte,
  input  logic             i_TX_DV,
  output logic             o_TX_Ready,
  output logic [CNT_W-1:0] o_RX_Count,
  output logic             o_RX_DV,
  output logic [7:0]       o_RX_Byte,
  output logic [7:0]       o_M_TX_Byte,
  output logic             o_M_TX_DV,
  input  logic             i_M_TX_Ready,
  input  logic             i_M_RX_DV,
  input  logic [7:0]       i_M_RX_Byte,
  output logic             o_SPI_CS_n
);

  localparam int GAP_W = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_TRANSFER    = 2'd1;
  localparam logic [1:0] ST_CS_INACTIVE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic [GAP_W-1:0] gap;
  logic [CNT_W-1:0] rx_idx;
  logic [CNT_W-1:0] tx_count_clamped;
  logic             accept;
  logic             xfer_start;

  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] cnt);
    if (int'(cnt) > MAX_BYTES_PER_CS) return CNT_W'(MAX_BYTES_PER_CS);
    return cnt;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] idx);
    if (int'(idx) >= MAX_BYTES_PER_CS - 1) return idx;
    return idx + CNT_W'(1);
  endfunction

  // The ~o_M_TX_DV term covers the cycle where the master has a DV but has not yet dropped ready.
  assign o_TX_Ready = i_M_TX_Ready & ~o_M_TX_DV &
                      ((state == ST_IDLE) | ((state == ST_TRANSFER) & (remaining != '0)));
  assign accept           = i_TX_DV & o_TX_Ready;
  assign tx_count_clamped = clamp_count(i_TX_Count);
  assign xfer_start       = accept & (state == ST_IDLE) & (tx_count_clamped != '0);

  // Stage p0: host byte to master, chip-select window and inter-transaction gap
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      gap         <= '0;
      o_SPI_CS_n  <= 1'b1;
      o_M_TX_DV   <= 1'b0;
      o_M_TX_Byte <= '0;
    end else begin
      o_M_TX_DV <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer_start) begin
            o_M_TX_DV   <= 1'b1;
            o_M_TX_Byte <= i_TX_Byte;
            remaining   <= tx_count_clamped - CNT_W'(1);
            o_SPI_CS_n  <= 1'b0;
            state       <= ST_TRANSFER;
          end
        end
        ST_TRANSFER: begin
          if (accept) begin
            o_M_TX_DV   <= 1'b1;
            o_M_TX_Byte <= i_TX_Byte;
            remaining   <= remaining - CNT_W'(1);
          end else if ((remaining == '0) && i_M_TX_Ready && !o_M_TX_DV) begin
            o_SPI_CS_n <= 1'b1;
            gap        <= GAP_W'(CS_INACTIVE_CLKS - 1);
            state      <= ST_CS_INACTIVE;
          end
        end
        ST_CS_INACTIVE: begin
          if (gap == '0) state <= ST_IDLE;
          else           gap   <= gap - GAP_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p0: master RX byte registered out with its index in the transaction
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= '0;
      o_RX_Count <= '0;
      rx_idx     <= '0;
    end else begin
      o_RX_DV   <= i_M_RX_DV;
      o_RX_Byte <= i_M_RX_Byte;
      if (xfer_start) begin
        rx_idx     <= '0;
        o_RX_Count <= '0;
      end else if (i_M_RX_DV) begin
        o_RX_Count <= rx_idx;
        rx_idx     <= sat_inc(rx_idx);
      end
    end
  end

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Directed bench for spi_cs_sequencer with a simple SPI master responder model.
module tb_spi_cs_sequencer;

  localparam int MAX_BYTES_PER_CS = 2;
  localparam int CS_INACTIVE_CLKS = 1;
  localparam int CNT_W = $clog2(MAX_BYTES_PER_CS + 1);

  logic             i_Clk = 1'b0;
  logic             i_Rst_L;
  logic [CNT_W-1:0] i_TX_Count;
  logic [7:0]       i_TX_Byte;
  logic             i_TX_DV;
  logic             o_TX_Ready;
  logic [CNT_W-1:0] o_RX_Count;
  logic             o_RX_DV;
  logic [7:0]       o_RX_Byte;
  logic [7:0]       o_M_TX_Byte;
  logic             o_M_TX_DV;
  logic             i_M_TX_Ready;
  logic             i_M_RX_DV;
  logic [7:0]       i_M_RX_Byte;
  logic             o_SPI_CS_n;

  int checks = 0;
  int errors = 0;
  int m_dv_cnt = 0;
  int cs_rise = 0;
  logic prev_cs = 1'b1;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx_b[$];
  int         exp_rx_c[$];
  logic [7:0] miso_q[$];

  logic [4:0] busy;
  logic [7:0] pend;

  spi_cs_sequencer #(
    .MAX_BYTES_PER_CS(MAX_BYTES_PER_CS),
    .CS_INACTIVE_CLKS(CS_INACTIVE_CLKS)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst_L(i_Rst_L),
    .i_TX_Count(i_TX_Count),
    .i_TX_Byte(i_TX_Byte),
    .i_TX_DV(i_TX_DV),
    .o_TX_Ready(o_TX_Ready),
    .o_RX_Count(o_RX_Count),
    .o_RX_DV(o_RX_DV),
    .o_RX_Byte(o_RX_Byte),
    .o_M_TX_Byte(o_M_TX_Byte),
    .o_M_TX_DV(o_M_TX_DV),
    .i_M_TX_Ready(i_M_TX_Ready),
    .i_M_RX_DV(i_M_RX_DV),
    .i_M_RX_Byte(i_M_RX_Byte),
    .o_SPI_CS_n(o_SPI_CS_n)
  );

  always #5 i_Clk = ~i_Clk;

  // Master model: drops ready for 16 cycles per byte, then returns the queued MISO byte.
  always @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      i_M_TX_Ready <= 1'b1;
      i_M_RX_DV    <= 1'b0;
      i_M_RX_Byte  <= 8'h00;
      busy         <= '0;
      pend         <= 8'h00;
    end else begin
      i_M_RX_DV <= 1'b0;
      if (o_M_TX_DV) begin
        i_M_TX_Ready <= 1'b0;
        busy         <= 5'd16;
        pend         <= (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
      end else if (busy == 5'd1) begin
        busy         <= '0;
        i_M_TX_Ready <= 1'b1;
        i_M_RX_DV    <= 1'b1;
        i_M_RX_Byte  <= pend;
      end else if (busy != '0) begin
        busy <= busy - 5'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge i_Clk) begin
    if (i_Rst_L) begin
      if (o_M_TX_DV) begin
        m_dv_cnt++;
        if (exp_tx.size() == 0) check("tx_unexpected", 32'(o_M_TX_Byte), 32'h100);
        else                    check("tx_byte", 32'(o_M_TX_Byte), 32'(exp_tx.pop_front()));
      end
      if (o_RX_DV) begin
        if (exp_rx_b.size() == 0) begin
          check("rx_unexpected", 32'(o_RX_Byte), 32'h100);
        end else begin
          check("rx_byte", 32'(o_RX_Byte), 32'(exp_rx_b.pop_front()));
          check("rx_count", 32'(o_RX_Count), 32'(exp_rx_c.pop_front()));
        end
      end
    end
    if (o_SPI_CS_n && !prev_cs) cs_rise++;
    prev_cs = o_SPI_CS_n;
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!o_TX_Ready && n < 200) begin
      @(negedge i_Clk);
      n++;
    end
    check(tag, 32'(o_TX_Ready), 32'd1);
  endtask

  task automatic finish_gap(input string tag, input bit poke);
    int n = 0;
    while (!o_SPI_CS_n && n < 300) begin
      @(negedge i_Clk);
      n++;
    end
    check({tag, "_cs_rise"}, 32'(o_SPI_CS_n), 32'd1);
    n = 0;
    while (!o_TX_Ready && o_SPI_CS_n && n < 50) begin
      i_TX_Count = CNT_W'(1);
      i_TX_Byte  = 8'h77;
      i_TX_DV    = poke && (n == 0);
      @(negedge i_Clk);
      n++;
    end
    i_TX_DV = 1'b0;
    check({tag, "_cs_gap"}, 32'(n), 32'(CS_INACTIVE_CLKS));
    check({tag, "_cs_high_idle"}, 32'({o_SPI_CS_n, o_TX_Ready}), 32'b11);
  endtask

  task automatic xfer(input string tag, input logic [CNT_W-1:0] cnt, input int n,
                      input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] m0, input logic [7:0] m1, input bit poke);
    int dv0 = m_dv_cnt;
    int cr0 = cs_rise;
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(i == 0 ? b0 : b1);
      miso_q.push_back(i == 0 ? m0 : m1);
      exp_rx_b.push_back(i == 0 ? m0 : m1);
      exp_rx_c.push_back(i);
    end
    for (int i = 0; i < n; i++) begin
      wait_ready({tag, "_rdy"});
      i_TX_Count = cnt;
      i_TX_Byte  = (i == 0) ? b0 : b1;
      i_TX_DV    = 1'b1;
      @(negedge i_Clk);
      i_TX_DV = 1'b0;
      if (i == 0) check({tag, "_cs_with_dv"}, 32'({o_SPI_CS_n, o_M_TX_DV}), 32'b01);
      if (poke && i == 0) begin
        repeat (3) @(negedge i_Clk);
        i_TX_Byte = 8'h99;
        i_TX_DV   = 1'b1;
        @(negedge i_Clk);
        i_TX_DV = 1'b0;
        check({tag, "_busy_cs_low"}, 32'(o_SPI_CS_n), 32'd0);
      end
    end
    finish_gap(tag, poke);
    check({tag, "_dv_pulses"}, 32'(m_dv_cnt - dv0), 32'(n));
    check({tag, "_cs_rises"}, 32'(cs_rise - cr0), 32'd1);
    check({tag, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
    check({tag, "_rx_left"}, 32'(exp_rx_b.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int dv0;
    i_Rst_L    = 1'b0;
    i_TX_DV    = 1'b0;
    i_TX_Byte  = 8'h00;
    i_TX_Count = '0;
    repeat (3) @(negedge i_Clk);
    check("rst_cs_n", 32'(o_SPI_CS_n), 32'd1);
    check("rst_m_dv", 32'(o_M_TX_DV), 32'd0);
    check("rst_m_byte", 32'(o_M_TX_Byte), 32'd0);
    check("rst_rx", 32'({o_RX_DV, o_RX_Byte, o_RX_Count}), 32'd0);
    i_Rst_L = 1'b1;
    @(negedge i_Clk);
    check("idle_tx_ready", 32'(o_TX_Ready), 32'd1);
    check("idle_cs_n", 32'(o_SPI_CS_n), 32'd1);

    // Two-byte transaction with independent MISO data
    xfer("two_byte", CNT_W'(2), 2, 8'hA5, 8'h3C, 8'h11, 8'h22, 1'b0);

    // Host holds DV high across the handshake
    dv0 = m_dv_cnt;
    exp_tx.push_back(8'h55);
    miso_q.push_back(8'h33);
    exp_rx_b.push_back(8'h33);
    exp_rx_c.push_back(0);
    wait_ready("held_rdy");
    i_TX_Count = CNT_W'(1);
    i_TX_Byte  = 8'h55;
    i_TX_DV    = 1'b1;
    repeat (5) @(negedge i_Clk);
    i_TX_DV = 1'b0;
    finish_gap("held", 1'b0);
    check("held_one_dv", 32'(m_dv_cnt - dv0), 32'd1);
    check("held_rx_left", 32'(exp_rx_b.size()), 32'd0);

    // DV pokes while master busy and during the CS-high gap
    xfer("poke", CNT_W'(2), 2, 8'hC8, 8'h8C, 8'h44, 8'h88, 1'b1);

    // Oversized count clamps to MAX_BYTES_PER_CS
    xfer("clamp", CNT_W'(3), 2, 8'h81, 8'h18, 8'hE7, 8'h7E, 1'b0);

    // Zero-length request is ignored
    dv0 = m_dv_cnt;
    i_TX_Count = '0;
    i_TX_Byte  = 8'hFF;
    i_TX_DV    = 1'b1;
    @(negedge i_Clk);
    i_TX_DV = 1'b0;
    repeat (3) @(negedge i_Clk);
    check("zero_cs_n", 32'(o_SPI_CS_n), 32'd1);
    check("zero_no_dv", 32'(m_dv_cnt - dv0), 32'd0);
    check("zero_idle", 32'(o_TX_Ready), 32'd1);

    // Async reset mid-transaction
    exp_tx.push_back(8'hC3);
    wait_ready("rst_rdy");
    i_TX_Count = CNT_W'(2);
    i_TX_Byte  = 8'hC3;
    i_TX_DV    = 1'b1;
    @(negedge i_Clk);
    i_TX_DV = 1'b0;
    repeat (3) @(negedge i_Clk);
    check("mid_cs_low", 32'(o_SPI_CS_n), 32'd0);
    i_Rst_L = 1'b0;
    #1;
    check("async_cs_n", 32'(o_SPI_CS_n), 32'd1);
    check("async_m_dv", 32'(o_M_TX_DV), 32'd0);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    @(negedge i_Clk);
    check("post_rst_idle", 32'({o_SPI_CS_n, o_TX_Ready, o_RX_Count}), 32'({1'b1, 1'b1, CNT_W'(0)}));
    xfer("after_rst", CNT_W'(1), 1, 8'h5A, 8'h00, 8'h66, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
